// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for the 8-bit counter datapath.
// Takes START/PAUSE/ABORT commands over valid/ready, drives the counter's
// enable and synchronous clear, and watches the fed-back count on C to run
// 0..LIMIT a programmable number of times before pulsing DONE.
module counter_sequencer #(
   parameter int WIDTH    = 8,
   parameter int REPEAT_W = 4
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                CMD_VALID,
   output logic                CMD_READY,
   input  logic [1:0]          CTRL,
   input  logic [WIDTH-1:0]    LIMIT,
   input  logic [REPEAT_W-1:0] REPEAT,
   input  logic [WIDTH-1:0]    C,
   output logic                CNT_EN,
   output logic                CNT_CLR,
   output logic                BUSY,
   output logic                DONE,
   output logic [REPEAT_W-1:0] RUNS_LEFT,
   output logic [1:0]          STATE
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   localparam logic [1:0] CMD_START = 2'b01;
   localparam logic [1:0] CMD_PAUSE = 2'b10;
   localparam logic [1:0] CMD_ABORT = 2'b11;

   localparam logic [REPEAT_W-1:0] ONE_RUN = {{(REPEAT_W-1){1'b0}}, 1'b1};

   state_t              r_state, w_state_nxt;
   logic [WIDTH-1:0]    r_lim, w_lim_nxt;
   logic [REPEAT_W-1:0] r_runs, w_runs_nxt;
   logic                r_done, w_done_nxt;
   logic                r_abort, w_abort_nxt;
   logic                w_accept;
   logic                w_term;

   // Commands are only refused during the single CLEAR cycle.
   assign w_accept  = CMD_VALID && (r_state != S_CLEAR);
   // Terminal detect: full-width unsigned compare while actively running.
   assign w_term    = (r_state == S_RUN) && (C == r_lim);

   assign CMD_READY = (r_state != S_CLEAR);
   assign CNT_EN    = (r_state == S_RUN) && (C != r_lim);
   assign CNT_CLR   = (r_state == S_CLEAR) || r_abort;
   assign BUSY      = (r_state != S_IDLE);
   assign DONE      = r_done;
   assign RUNS_LEFT = r_runs;
   assign STATE     = r_state;

   // Next-state logic; branch order encodes ABORT > START > terminal > PAUSE,
   // so a PAUSE landing on the terminal edge is consumed and dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_lim_nxt   = r_lim;
      w_runs_nxt  = r_runs;
      w_done_nxt  = 1'b0;
      w_abort_nxt = 1'b0;
      if (w_accept && (CTRL == CMD_ABORT)) begin
         w_state_nxt = S_IDLE;
         w_runs_nxt  = '0;
         w_abort_nxt = 1'b1;
      end else if (w_accept && (CTRL == CMD_START)) begin
         w_state_nxt = S_CLEAR;
         w_lim_nxt   = LIMIT;
         w_runs_nxt  = (REPEAT == '0) ? ONE_RUN : REPEAT;
      end else if (w_term) begin
         // <= 1 rather than == 1 so a corrupted zero count cannot underflow.
         if (r_runs <= ONE_RUN) begin
            w_state_nxt = S_IDLE;
            w_runs_nxt  = '0;
            w_done_nxt  = 1'b1;
         end else begin
            w_state_nxt = S_CLEAR;
            w_runs_nxt  = r_runs - ONE_RUN;
         end
      end else if (w_accept && (CTRL == CMD_PAUSE)) begin
         if (r_state == S_RUN)       w_state_nxt = S_HOLD;
         else if (r_state == S_HOLD) w_state_nxt = S_RUN;
      end else if (r_state == S_CLEAR) begin
         w_state_nxt = S_RUN;
      end
   end

   // State, latched limit/repeat and the one-cycle DONE/abort-clear pulses.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
         r_lim   <= '0;
         r_runs  <= '0;
         r_done  <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_lim   <= w_lim_nxt;
         r_runs  <= w_runs_nxt;
         r_done  <= w_done_nxt;
         r_abort <= w_abort_nxt;
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: drives command sequences into counter_sequencer with
// a behavioural 8-bit counter closing the loop on C. Expected per-cycle
// outputs come from a timeline plan built arithmetically from LIMIT/REPEAT,
// pause points and hold lengths.
module tb_counter_sequencer;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_START = 2'b01;
   localparam logic [1:0] CMD_PAUSE = 2'b10;
   localparam logic [1:0] CMD_ABORT = 2'b11;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       CMD_VALID = 1'b0;
   logic       CMD_READY;
   logic [1:0] CTRL = 2'b00;
   logic [7:0] LIMIT = 8'd0;
   logic [3:0] REPEAT = 4'd0;
   logic [7:0] C;
   logic       CNT_EN, CNT_CLR, BUSY, DONE;
   logic [3:0] RUNS_LEFT;
   logic [1:0] STATE;

   int n_chk = 0;
   int n_fail = 0;
   int mc = 0;     // model's view of C at the end of the plan built so far
   int cyc = 0;

   typedef struct {
      logic [1:0] st;
      logic [3:0] rl;
      logic [7:0] c;
      logic       en, clr, done;
      logic       cv;
      logic [1:0] cmd;
      logic [7:0] lim;
      logic [3:0] rep;
   } ent_t;

   ent_t plan[$];

   counter_sequencer #(.WIDTH(8), .REPEAT_W(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CTRL(CTRL), .LIMIT(LIMIT), .REPEAT(REPEAT), .C(C), .CNT_EN(CNT_EN),
      .CNT_CLR(CNT_CLR), .BUSY(BUSY), .DONE(DONE), .RUNS_LEFT(RUNS_LEFT), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   // Counter datapath: clear has priority over enable.
   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)     C <= 8'd0;
      else if (CNT_CLR) C <= 8'd0;
      else if (CNT_EN)  C <= C + 8'd1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs();
      return {13'd0, STATE, RUNS_LEFT, C, CNT_EN, CNT_CLR, BUSY, DONE, CMD_READY};
   endfunction

   function automatic logic [31:0] expv(input ent_t e);
      return {13'd0, e.st, e.rl, e.c, e.en, e.clr, (e.st != 2'd0), e.done, (e.st != 2'd1)};
   endfunction

   task automatic pe(input int st, input int rl, input int c, input bit en, input bit clr,
                     input bit done, input bit cv, input logic [1:0] cmd, input int lim, input int rep);
      ent_t e;
      e.st = 2'(st); e.rl = 4'(rl); e.c = 8'(c);
      e.en = en; e.clr = clr; e.done = done;
      e.cv = cv; e.cmd = cmd; e.lim = 8'(lim); e.rep = 4'(rep);
      plan.push_back(e);
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++)
         pe(0, 0, mc, 0, 0, 0, 1'($urandom % 2), ($urandom % 2) ? CMD_PAUSE : CMD_NOP, 0, 0);
   endtask

   task automatic add_start(input int lim, input int rep);
      pe(0, 0, mc, 0, 0, 0, 1, CMD_START, lim, rep);
   endtask

   // One full START sequence: R runs of (1 CLEAR + lim+1 RUN cycles), a hold of
   // h cycles after a PAUSE issued at count pk in the first run, optional PAUSE
   // on the first terminal cycle (tp), and an optional cut at count `cut` in the
   // first run carrying command ccmd (nl/nr are its LIMIT/REPEAT).
   task automatic add_seq(input int lim, input int rep, input int pk, input int h, input bit tp,
                          input int cut, input logic [1:0] ccmd, input int nl, input int nr);
      int R;
      R = (rep == 0) ? 1 : rep;
      for (int r = 0; r < R; r++) begin
         pe(1, R - r, mc, 0, 1, 0, 0, CMD_NOP, 0, 0);
         for (int c = 0; c <= lim; c++) begin
            if (r == 0 && c == cut) begin
               pe(2, R - r, c, (c != lim), 0, 0, 1, ccmd, nl, nr);
               mc = (c != lim) ? c + 1 : c;
               return;
            end
            pe(2, R - r, c, (c != lim), 0, 0, (r == 0 && (c == pk || (tp && c == lim))),
               CMD_PAUSE, 0, 0);
            if (r == 0 && c == pk)
               for (int i = 0; i < h; i++) pe(3, R - r, c + 1, 0, 0, 0, (i == h - 1), CMD_PAUSE, 0, 0);
         end
         mc = lim;
      end
      pe(0, 0, lim, 0, 0, 1, 0, CMD_NOP, 0, 0);
   endtask

   // Check then drive the first n plan entries, one per cycle, at the negedge.
   task automatic run_plan(input int n);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("cyc%0d", cyc), obs(), expv(plan[i]));
         CMD_VALID = plan[i].cv;
         if (plan[i].cv) begin
            CTRL = plan[i].cmd; LIMIT = plan[i].lim; REPEAT = plan[i].rep;
         end else begin
            CTRL = 2'($urandom); LIMIT = 8'($urandom); REPEAT = 4'($urandom);
         end
         @(negedge CLK);
         cyc++;
      end
      plan.delete();
   endtask

   task automatic simple(input int lim, input int rep);
      add_idle(2); add_start(lim, rep);
      add_seq(lim, rep, -1, 0, 0, -1, CMD_NOP, 0, 0);
      run_plan(plan.size());
   endtask

   initial begin
      int base, lim, rep, pk, h;
      bit tp;
      repeat (2) @(negedge CLK);
      chk("reset", obs(), {13'd0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      RESET_N = 1'b1;
      @(negedge CLK);

      simple(5, 1);
      simple(3, 3);
      // PAUSE issued at C=3, six HOLD cycles at C=4, then RESUME
      add_idle(2); add_start(10, 1);
      add_seq(10, 1, 3, 6, 0, -1, CMD_NOP, 0, 0);
      run_plan(plan.size());
      // ABORT at C=50: one IDLE cycle with CNT_CLR, then C=0
      add_idle(1); add_start(200, 1);
      add_seq(200, 1, -1, 0, 0, 50, CMD_ABORT, 0, 0);
      pe(0, 0, mc, 0, 1, 0, 0, CMD_NOP, 0, 0);
      mc = 0;
      add_idle(3);
      run_plan(plan.size());
      simple(0, 0);
      // START while running restarts with the new limit, no DONE for the old one
      add_idle(1); add_start(8, 2);
      add_seq(8, 2, -1, 0, 0, 4, CMD_START, 2, 1);
      add_seq(2, 1, -1, 0, 0, -1, CMD_NOP, 0, 0);
      run_plan(plan.size());
      simple(255, 1);
      // PAUSE on the terminal cycle is discarded
      add_idle(1); add_start(4, 2);
      add_seq(4, 2, -1, 0, 1, -1, CMD_NOP, 0, 0);
      run_plan(plan.size());

      // Asynchronous reset mid-cycle while C=7
      add_idle(1); add_start(9, 2);
      base = plan.size();
      add_seq(9, 2, -1, 0, 0, -1, CMD_NOP, 0, 0);
      run_plan(base + 8);
      chk("pre_rst_c", {24'd0, C}, 32'd7);
      #2 RESET_N = 1'b0;
      CMD_VALID = 1'b0;
      #1 chk("async_rst", obs(), {13'd0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge CLK);
      RESET_N = 1'b1;
      mc = 0;
      simple(2, 1);

      for (int k = 0; k < 8; k++) begin
         lim = $urandom_range(0, 20);
         rep = $urandom_range(0, 4);
         pk = -1; h = 0;
         if (lim > 0 && ($urandom % 2)) begin
            pk = $urandom_range(0, lim - 1);
            h = $urandom_range(1, 5);
         end
         tp = 1'($urandom % 2);
         add_idle($urandom_range(1, 3)); add_start(lim, rep);
         add_seq(lim, rep, pk, h, tp, -1, CMD_NOP, 0, 0);
         add_idle(1);
         run_plan(plan.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller that sequences the 8-bit counter datapath (C[7:0]) for interconnect and SDF timing tests.
- Accepts 2-bit CTRL commands over a valid/ready handshake.
- Drives the counter's enable and synchronous clear, and watches the counter value fed back on C.
- Runs the counter from 0 to a latched LIMIT, repeats this a programmable number of times, then signals DONE.

Parameters:
- WIDTH, 8, counter/limit width.
- REPEAT_W, 4, width of the repeat count.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted on edge when CMD_VALID&CMD_READY.
- CTRL  in  2  command code: 00 NOP, 01 START, 10 PAUSE/RESUME, 11 ABORT.
- LIMIT  in  WIDTH  terminal value, latched on START.
- REPEAT  in  REPEAT_W  number of runs, latched on START.
- C  in  WIDTH  counter value fed back from the datapath.
- CNT_EN  out  1  counter increment enable.
- CNT_CLR  out  1  counter synchronous clear (counter gives it priority over CNT_EN).
- BUSY  out  1  high when state != IDLE.
- DONE  out  1  one-cycle pulse after the final run completes.
- RUNS_LEFT  out  REPEAT_W  remaining runs including the current one.
- STATE  out  2  IDLE=0, CLEAR=1, RUN=2, HOLD=3.

Behaviour:
- Reset (async, RESET_N=0):
  - State=IDLE; lim_q=0, runs_left=0; DONE=0, abort_q=0.
  - CNT_EN=0, CNT_CLR=0, BUSY=0, CMD_READY=1.
  - Release is synchronous to the next CLK edge.
- Outputs:
  - CMD_READY = (state != CLEAR).
  - CNT_EN = (state==RUN) && (C != lim_q).
  - CNT_CLR = (state==CLEAR) || abort_q.
  - DONE and abort_q are registered.
- START accepted at edge t:
  - Latch lim_q=LIMIT and runs_left=max(REPEAT,1); REPEAT=0 is treated as 1.
  - Cycle t+1: state CLEAR. Cycle t+2: state RUN with C=0.
- RUN:
  - Counter advances 1 per cycle.
  - On an edge with C==lim_q (terminal detect):
    - If runs_left==1: runs_left=0, next state IDLE, DONE=1 for exactly one cycle.
    - Else: runs_left-1, next state CLEAR.
  - One run = 1 CLEAR cycle + (lim_q+1) RUN cycles.
- LIMIT=0: terminal is detected in the first RUN cycle; CNT_EN is never asserted.
- PAUSE/RESUME (10):
  - RUN→HOLD, HOLD→RUN.
  - HOLD: CNT_EN=0; C is held by the counter; runs_left is unchanged.
  - In IDLE: accepted, no effect.
- ABORT (11):
  - Any state→IDLE.
  - abort_q=1 for one cycle, giving a CNT_CLR pulse while in IDLE.
  - runs_left=0; no DONE.
- NOP (00): accepted, no effect.
- START while BUSY (RUN/HOLD): accepted; relatches LIMIT/REPEAT and restarts via CLEAR; no DONE for the interrupted sequence.
- Same-edge priority: ABORT > START > terminal detect > PAUSE.
  - A PAUSE coinciding with terminal detect is consumed and discarded.
- C is compared unsigned at full WIDTH. lim_q=2^WIDTH-1 is legal, and the counter never wraps under control.
- If C jumps past lim_q (external fault): keep counting; terminal fires when the counter wraps to lim_q.
- Reset mid-run: immediate return to reset values; any pending DONE is lost.

Test Plan:
- Reset, then START with LIMIT=5, REPEAT=1 → CLEAR 1 cycle.
  - CNT_EN high for 5 cycles; C=0..5.
  - DONE pulses once, 1 cycle after C==5 is detected; BUSY falls the same cycle; total 8 cycles from accept to DONE.
- START with LIMIT=3, REPEAT=3 → three CLEAR+RUN sequences of 5 cycles each.
  - RUNS_LEFT steps 3,2,1,0; a single DONE after the third run.
- START with LIMIT=10; PAUSE at C=4; wait 6 cycles; RESUME.
  - C holds at 4 and CNT_EN=0 during HOLD; counting resumes to 10; DONE is delayed by exactly the hold length.
- START with LIMIT=200; ABORT at C=50 → next cycle IDLE, CNT_CLR pulses 1 cycle, C=0 afterward, no DONE, RUNS_LEFT=0.
- LIMIT=0, REPEAT=0 → 1 run; CNT_EN never asserted; DONE 3 cycles after accept.
- START with LIMIT=9, REPEAT=2; assert RESET_N=0 asynchronously mid-clock at C=7 → all outputs go to reset values without waiting for an edge; after release, a new START with LIMIT=2 completes normally.
